// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions used by the key schedule and the
//                round datapath. It provides the key-expansion FSM state
//                type, the round count, the initial round constant and the
//                GF(2^8) xtime helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } aes_state_t;

    localparam int         AES_NR        = 10;
    localparam logic [7:0] AES_RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8), reducing by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand_if
//  Description : Cipher-key input channel and round-key output channel of
//                the AES-128 key schedule. Both channels use valid/ready.
//                slave  : key-schedule side (accepts keys, emits round keys)
//                master : producer/consumer side
//  Ports       : key_valid, key_in[127:0], key_ready,
//                rk_valid, rk_ready, rk_out[127:0], rk_round[3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_expand_if;

    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    modport slave (
        input  key_valid, key_in, rk_ready,
        output key_ready, rk_valid, rk_out, rk_round
    );

    modport master (
        output key_valid, key_in, rk_ready,
        input  key_ready, rk_valid, rk_out, rk_round
    );

endinterface
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box, one byte in, one byte out.
//                It is shared by the key schedule (SubWord) and sub-bytes.
//  Ports       : i_byte[7:0] - input byte
//                o_byte[7:0] - substituted byte
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  wire logic [7:0] i_byte,
    output logic      [7:0] o_byte
);

    // Entry 0 sits in the most significant byte, so entry i starts at bit
    // 8*(255-i), which is simply {~i, 3'b000}.
    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    wire logic [10:0] w_bit_ofs = {~i_byte, 3'b000};

    assign o_byte = C_SBOX[w_bit_ofs +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand
//  Description : Iterative AES-128 key schedule. It accepts a cipher key and
//                emits round keys 0..10, one per rk_valid/rk_ready handshake.
//                The schedule advances one round per accepted beat.
//                Optional feature macro: AES_KEY_EXPAND_LAST_KEY_EN adds the
//                last_key output, which holds the round-10 key of the most
//                recent complete expansion.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                kif (slave)    - key input and round-key output channels
//                busy           - expansion in progress
//                last_key[127:0]- final round key (macro builds only)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand
    import aes_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    aes_key_expand_if.slave    kif,
    output logic               busy
`ifdef AES_KEY_EXPAND_LAST_KEY_EN
    ,
    output logic [127:0]       last_key
`endif
);

    localparam logic [3:0] C_LAST_ROUND = 4'(AES_NR);

    aes_state_t   r_state;
    aes_state_t   w_state_nxt;
    logic [127:0] r_rk;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;

    logic         w_key_fire;
    logic         w_rk_fire;
    logic         w_last;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_temp;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;

    assign w_key_fire = (r_state == ST_IDLE) && kif.key_valid;
    assign w_rk_fire  = (r_state == ST_RUN)  && kif.rk_ready;
    assign w_last     = (r_round == C_LAST_ROUND);

    // RotWord of w3: left byte rotate, byte 0 moves to the end.
    assign w_rot = {r_rk[23:0], r_rk[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*gi +: 8]),
            .o_byte (w_sub[8*gi +: 8])
        );
    end

    assign w_temp = w_sub ^ {r_rcon, 24'h0};
    assign w_n0   = r_rk[127:96] ^ w_temp;
    assign w_n1   = r_rk[95:64]  ^ w_n0;
    assign w_n2   = r_rk[63:32]  ^ w_n1;
    assign w_n3   = r_rk[31:0]   ^ w_n2;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (kif.key_valid)           w_state_nxt = ST_RUN;
            ST_RUN:  if (kif.rk_ready && w_last)  w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rk    <= '0;
            r_round <= '0;
            r_rcon  <= AES_RCON_INIT;
        end else begin
            r_state <= w_state_nxt;
            if (w_key_fire) begin
                r_rk    <= kif.key_in;
                r_round <= '0;
                r_rcon  <= AES_RCON_INIT;
            end else if (w_rk_fire && !w_last) begin
                r_rk    <= {w_n0, w_n1, w_n2, w_n3};
                r_round <= r_round + 4'd1;
                r_rcon  <= xtime(r_rcon);
            end
            // On the round-10 handshake the key and index are left as-is.
        end
    end

`ifdef AES_KEY_EXPAND_LAST_KEY_EN
    logic [127:0] r_last_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_key <= '0;
        end else if (w_rk_fire && w_last) begin
            r_last_key <= r_rk;
        end
    end

    assign last_key = r_last_key;
`endif

    assign kif.key_ready = (r_state == ST_IDLE);
    assign kif.rk_valid  = (r_state == ST_RUN);
    assign kif.rk_out    = r_rk;
    assign kif.rk_round  = r_round;
    assign busy          = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_expand
//  Description : Self-checking bench for aes_key_expand. A reference key
//                schedule computed from the FIPS-197 word recurrence (with an
//                S-box derived from GF(2^8) inversion plus the affine map)
//                fills a scoreboard queue on every key acceptance; a monitor
//                compares every presented round key against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

    localparam logic [127:0] C_FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] C_FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] C_ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef AES_KEY_EXPAND_LAST_KEY_EN
    logic [127:0] last_key;
`endif

    aes_key_expand_if kif ();

    aes_key_expand dut (
        .clk      (clk),
        .rst      (rst),
        .kif      (kif),
        .busy     (busy)
`ifdef AES_KEY_EXPAND_LAST_KEY_EN
        ,
        .last_key (last_key)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int beats  = 0;
    int stall_pct = 0;
    bit ready_hold = 1'b0;
    int acc_cyc[$];

    logic [7:0]   sb_ref [256];
    logic [127:0] exp_rk [11];
    logic [131:0] exp_q  [$];
    logic [127:0] got    [16];
    logic [127:0] fips_got [11];
    bit           lk_hold_en = 1'b0;
    logic [127:0] lk_hold;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b = 8'(x);
            logic [7:0] inv = b;
            for (int k = 0; k < 253; k++) inv = gmul(inv, b);   // b^254 = b^-1
            sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // ---------------- ready driver ----------------
    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (!ready_hold) kif.rk_ready = ($urandom_range(99) >= stall_pct);
    end

    // ---------------- acceptance observer: pushes expected schedule ----------------
    always @(negedge clk) begin
        if (!rst && kif.key_valid && kif.key_ready) begin
            expand(kif.key_in);
            for (int r = 0; r < 11; r++) exp_q.push_back({4'(r), exp_rk[r]});
            acc_cyc.push_back(cyc);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && kif.rk_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got round %0d key %h expected none", kif.rk_round, kif.rk_out);
            end else begin
                if ({kif.rk_round, kif.rk_out} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL sb_beat: got round %0d key %h expected round %0d key %h",
                             kif.rk_round, kif.rk_out, exp_q[0][131:128], exp_q[0][127:0]);
                end
                if (kif.rk_ready) begin
                    got[kif.rk_round] = kif.rk_out;
                    beats++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_key(input logic [127:0] k);
        int n = 0;
        while (!kif.key_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!kif.key_ready) begin
            errors++; checks++;
            $display("FAIL key_ready_timeout: got key_ready=0 expected 1");
        end
        kif.key_in    = k;
        kif.key_valid = 1'b1;
        @(posedge clk); #1;
        kif.key_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        forever begin
            @(posedge clk); #1;
`ifdef AES_KEY_EXPAND_LAST_KEY_EN
            if (lk_hold_en && busy) chk("last_key_hold", last_key, lk_hold);
`endif
            if (!busy && kif.key_ready && exp_q.size() == 0) break;
            if (++n > budget) begin
                errors++; checks++;
                $display("FAIL run_timeout: got %0d pending beats expected 0", exp_q.size());
                break;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst = 1'b1;
        kif.key_valid = 1'b0;
        kif.key_in    = '0;
        kif.rk_ready  = 1'b0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", 128'(kif.key_ready), 128'(1));
        chk("rst_rk_valid",  128'(kif.rk_valid),  128'(0));
        chk("rst_busy",      128'(busy),          128'(0));
        chk("rst_rk_out",    kif.rk_out,          128'(0));
        chk("rst_rk_round",  128'(kif.rk_round),  128'(0));
`ifdef AES_KEY_EXPAND_LAST_KEY_EN
        chk("rst_last_key",  last_key,            128'(0));
`endif
        rst = 1'b0;

        // FIPS-197 key, no stalls
        stall_pct = 0; beats = 0;
        send_key(C_FIPS_KEY);
        wait_done(200);
        chk("fips_beats", 128'(beats), 128'(11));
        chk("fips_r0",  got[0],  C_FIPS_KEY);
        chk("fips_r1",  got[1],  C_FIPS_R1);
        chk("fips_r10", got[10], C_FIPS_R10);
        for (int r = 0; r < 11; r++) fips_got[r] = got[r];
`ifdef AES_KEY_EXPAND_LAST_KEY_EN
        chk("fips_last_key", last_key, C_FIPS_R10);
        lk_hold = C_FIPS_R10; lk_hold_en = 1'b1;
`endif

        // all-zero key
        beats = 0;
        send_key(128'h0);
        wait_done(200);
        lk_hold_en = 1'b0;
        chk("zero_beats", 128'(beats), 128'(11));
        chk("zero_r1",  got[1],  C_ZERO_R1);
        chk("zero_r10", got[10], C_ZERO_R10);
`ifdef AES_KEY_EXPAND_LAST_KEY_EN
        chk("zero_last_key", last_key, C_ZERO_R10);
`endif

        // FIPS key with random consumer stalls
        stall_pct = 40; beats = 0;
        send_key(C_FIPS_KEY);
        wait_done(400);
        chk("stall_beats", 128'(beats), 128'(11));
        for (int r = 0; r < 11; r++) chk($sformatf("stall_r%0d", r), got[r], fips_got[r]);

        // key_valid pulses during RUN, then a back-to-back second key
        stall_pct = 0; beats = 0;
        send_key({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 5; i++) begin
            kif.key_valid = 1'b1;
            kif.key_in    = {$urandom, $urandom, $urandom, $urandom};
            chk("run_key_ready", 128'(kif.key_ready), 128'(0));
            @(posedge clk); #1;
        end
        kif.key_in = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!kif.key_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        kif.key_valid = 1'b0;
        wait_done(200);
        chk("b2b_beats", 128'(beats), 128'(22));
        if (acc_cyc.size() >= 2)
            chk("b2b_spacing", 128'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 128'(12));

        // reset at round 5
        beats = 0;
        send_key({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        while (!(kif.rk_valid && kif.rk_round == 4'd5) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ready_hold = 1'b1;
        kif.rk_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rk_valid",  128'(kif.rk_valid),  128'(0));
        chk("mid_rst_key_ready", 128'(kif.key_ready), 128'(1));
        chk("mid_rst_rk_round",  128'(kif.rk_round),  128'(0));
        rst = 1'b0;
        exp_q.delete();
        ready_hold = 1'b0;
        beats = 0;
        send_key({$urandom, $urandom, $urandom, $urandom});
        wait_done(200);
        chk("post_rst_beats", 128'(beats), 128'(11));

        // random keys with random stalls
        stall_pct = 25;
        for (int k = 0; k < 4; k++) begin
            beats = 0;
            send_key({$urandom, $urandom, $urandom, $urandom});
            wait_done(400);
            chk("rand_beats", 128'(beats), 128'(11));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
